// File: rtl/seg_pkg.sv
// Shared glyph constants and scan state encoding for seg_scan_ctrl.
// Optional macro SEG_LEADING_ZERO_BLANK_EN is consumed by seg_scan_ctrl.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        GUARD
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_HEX [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational nibble to active-low gfedcba segment decoder.
// A blanked digit yields all segments off.
module hex_seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    // Glyph lookup with blank override
    always_comb begin
        seg = SEG_HEX[nibble];
        if (blank) seg = SEG_BLANK;
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with frame-synchronous update.
// Define SEG_LEADING_ZERO_BLANK_EN to suppress leading zero digits.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 500
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          load_valid,
    input  logic [4*NUM_DIGITS-1:0]       load_data,
    input  logic [NUM_DIGITS-1:0]         blank_mask,
    output logic                          load_ready,
    output logic [6:0]                    seg,
    output logic [NUM_DIGITS-1:0]         dig_an,
    output logic [$clog2(NUM_DIGITS)-1:0] cur_digit,
    output logic                          frame_done
);

    localparam int DW   = $clog2(NUM_DIGITS);
    localparam int TMAX = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV
                                                       : GUARD_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int GL   = (GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0;

    localparam logic [TW-1:0] DRV_LAST = TW'(REFRESH_DIV - 1);
    localparam logic [TW-1:0] GRD_LAST = TW'(GL);
    localparam logic [DW-1:0] LAST_DIG = DW'(NUM_DIGITS - 1);

    scan_state_t state, state_nx;
    logic [DW-1:0] dig, dig_nx, dig_inc;
    logic [TW-1:0] tmr, tmr_nx;
    logic          wrap;

    logic [4*NUM_DIGITS-1:0] active, pending;
    logic                    pending_full;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic [3:0]              cur_nib;
    logic                    cur_blank;
    logic [6:0]              dec_seg;

    assign dig_inc    = (dig == LAST_DIG) ? '0 : dig + 1'b1;
    assign load_ready = !pending_full;
    assign cur_digit  = dig;
    assign cur_nib    = active[dig*4 +: 4];
    assign cur_blank  = blank_mask[dig] | lz_mask[dig];

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // Blank digit i>0 when it and every higher nibble are zero
    always_comb begin : lz_scan
        logic hi_zero;
        hi_zero = 1'b1;
        lz_mask = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            hi_zero    = hi_zero & (active[i*4 +: 4] == 4'h0);
            lz_mask[i] = hi_zero;
        end
    end
`else
    assign lz_mask = '0;
`endif

    hex_seg_decode u_dec (
        .nibble (cur_nib),
        .blank  (cur_blank),
        .seg    (dec_seg)
    );

    // Next-state logic: drive/guard sequencing, digit advance, frame wrap
    always_comb begin
        state_nx = state;
        dig_nx   = dig;
        tmr_nx   = tmr;
        wrap     = 1'b0;
        if (!enable) begin
            state_nx = IDLE;
            dig_nx   = '0;
            tmr_nx   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_nx = DRIVE;
                    dig_nx   = '0;
                    tmr_nx   = '0;
                end
                DRIVE: begin
                    if (tmr == DRV_LAST) begin
                        tmr_nx = '0;
                        if (GUARD_CYCLES == 0) begin
                            dig_nx = dig_inc;
                            wrap   = (dig == LAST_DIG);
                        end else begin
                            state_nx = GUARD;
                        end
                    end else begin
                        tmr_nx = tmr + 1'b1;
                    end
                end
                GUARD: begin
                    if (tmr == GRD_LAST) begin
                        state_nx = DRIVE;
                        tmr_nx   = '0;
                        dig_nx   = dig_inc;
                        wrap     = (dig == LAST_DIG);
                    end else begin
                        tmr_nx = tmr + 1'b1;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    dig_nx   = '0;
                    tmr_nx   = '0;
                end
            endcase
        end
    end

    // Scan state register and frame pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            dig        <= '0;
            tmr        <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            dig        <= dig_nx;
            tmr        <= tmr_nx;
            frame_done <= wrap;
        end
    end

    // Double buffer: accept into pending, commit to active on frame wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            active       <= '0;
            pending      <= '0;
            pending_full <= 1'b0;
        end else begin
            if (load_valid && !pending_full) begin
                pending      <= load_data;
                pending_full <= 1'b1;
            end
            if (wrap && pending_full) begin
                active       <= pending;
                pending_full <= 1'b0;
            end
        end
    end

    // Registered pin drive; segments and anodes switch together
    always_ff @(posedge clk) begin
        if (rst) begin
            seg    <= SEG_BLANK;
            dig_an <= '1;
        end else if (state == DRIVE) begin
            seg    <= dec_seg;
            dig_an <= ~(NUM_DIGITS'(1) << dig);
        end else begin
            seg    <= SEG_BLANK;
            dig_an <= '1;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (4 digits, 4-cycle drive, 1-cycle guard).
// Honours SEG_LEADING_ZERO_BLANK_EN when defined for the build.
module tb_seg_scan_ctrl;

    localparam int N     = 4;
    localparam int RD    = 4;
    localparam int G     = 1;
    localparam int P     = RD + G;
    localparam int FRAME = N * P;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = '0;
    logic [3:0]  blank_mask = '0;
    logic        load_ready;
    logic [6:0]  seg;
    logic [3:0]  dig_an;
    logic [1:0]  cur_digit;
    logic        frame_done;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .NUM_DIGITS   (N),
        .REFRESH_DIV  (RD),
        .GUARD_CYCLES (G)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .load_valid (load_valid),
        .load_data  (load_data),
        .blank_mask (blank_mask),
        .load_ready (load_ready),
        .seg        (seg),
        .dig_an     (dig_an),
        .cur_digit  (cur_digit),
        .frame_done (frame_done)
    );

    int nvec = 0;
    int nerr = 0;

    // reference model: position within frame instead of state/timer
    logic        m_run = 1'b0;
    int          m_pos = 0;
    logic [15:0] m_act = '0;
    logic [15:0] m_pend = '0;
    logic        m_full = 1'b0;
    logic [6:0]  m_seg = 7'h7F;
    logic [3:0]  m_an = 4'hF;
    logic        m_fd = 1'b0;

    logic [14:0] sbq[$];
    logic [3:0]  e_an;
    logic        acc;
    logic        watch = 1'b0;
    logic [6:0]  watch_g [4];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40; 4'h1: return 7'h79;
            4'h2: return 7'h24; 4'h3: return 7'h30;
            4'h4: return 7'h19; 4'h5: return 7'h12;
            4'h6: return 7'h02; 4'h7: return 7'h78;
            4'h8: return 7'h00; 4'h9: return 7'h10;
            4'hA: return 7'h08; 4'hB: return 7'h03;
            4'hC: return 7'h46; 4'hD: return 7'h21;
            4'hE: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    function automatic logic lzb(input int d);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        return (d > 0) && ((m_act >> (4 * d)) == 16'h0);
`else
        return (d < 0);
`endif
    endfunction

    task automatic model_step(output logic a);
        int   d;
        logic drv;
        logic commit;
        logic old_full;
        a = 1'b0;
        commit = 1'b0;
        if (rst) begin
            m_run = 1'b0; m_pos = 0; m_act = '0; m_pend = '0;
            m_full = 1'b0; m_seg = 7'h7F; m_an = 4'hF; m_fd = 1'b0;
        end else begin
            drv = m_run && ((m_pos % P) < RD);
            d   = m_run ? m_pos / P : 0;
            if (drv) begin
                m_seg = (blank_mask[d] || lzb(d)) ? 7'h7F
                                                  : glyph(m_act[d*4 +: 4]);
                m_an  = ~(4'b0001 << d);
            end else begin
                m_seg = 7'h7F;
                m_an  = 4'hF;
            end
            m_fd = 1'b0;
            if (!enable) begin
                m_run = 1'b0; m_pos = 0;
            end else if (!m_run) begin
                m_run = 1'b1; m_pos = 0;
            end else if (m_pos == FRAME - 1) begin
                m_pos = 0; m_fd = 1'b1; commit = 1'b1;
            end else begin
                m_pos++;
            end
            old_full = m_full;
            if (load_valid && !old_full) begin
                m_pend = load_data; m_full = 1'b1; a = 1'b1;
            end
            if (commit && old_full) begin
                m_act = m_pend; m_full = 1'b0;
            end
        end
        sbq.push_back({m_seg, m_an, 2'(m_run ? m_pos / P : 0), m_fd, ~m_full});
        e_an = m_an;
    endtask

    task automatic tick();
        logic        a;
        logic [14:0] exp;
        logic [14:0] obs;
        model_step(a);
        acc = a;
        @(posedge clk);
        #1;
        exp = sbq.pop_front();
        obs = {seg, dig_an, cur_digit, frame_done, load_ready};
        chk("scan", 32'(obs), 32'(exp));
        if (watch && e_an != 4'hF)
            for (int d = 0; d < N; d++)
                if (!e_an[d]) chk("glyph", 32'(seg), 32'(watch_g[d]));
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic load_val(input logic [15:0] v);
        load_data  = v;
        load_valid = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 200 && !acc; k++) tick();
        load_valid = 1'b0;
        chk("load_acc", 32'(acc), 32'd1);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_seg"}, 32'(seg), 32'h7F);
        chk({tag, "_an"}, 32'(dig_an), 32'hF);
        chk({tag, "_rdy"}, 32'(load_ready), 32'd1);
        chk({tag, "_cur"}, 32'(cur_digit), 32'd0);
        chk({tag, "_fd"}, 32'(frame_done), 32'd0);
    endtask

    initial begin
        int k;
        rst = 1'b1;
        run(2);
        chk_reset_outs("rst");

        rst = 1'b0;
        enable = 1'b1;
        load_val(16'h12AF);
        run(22);
        watch_g = '{7'h0E, 7'h08, 7'h24, 7'h79};
        watch = 1'b1;
        run(20);
        watch = 1'b0;

        run(7);
        load_val(16'h0001);
        chk("rdy_low", 32'(load_ready), 32'd0);
        load_val(16'h0002);
        watch_g = '{7'h79, 7'h40, 7'h40, 7'h40};
        watch = 1'b1;
        run(19);
        watch = 1'b0;

        for (k = 0; k < 100; k++) begin
            if (m_run && (m_pos / P) == 2 && (m_pos % P) < RD) break;
            tick();
        end
        chk("find_d2", 32'(k < 100), 32'd1);
        enable = 1'b0;
        run(2);
        chk("dark_an", 32'(dig_an), 32'hF);
        chk("dark_seg", 32'(seg), 32'h7F);
        run(3);
        enable = 1'b1;
        run(25);

        blank_mask = 4'b0100;
        load_val(16'h8888);
        run(22);
        watch_g = '{7'h00, 7'h00, 7'h7F, 7'h00};
        watch = 1'b1;
        run(20);
        watch = 1'b0;
        blank_mask = 4'b0000;

        load_val(16'h0030);
        run(22);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        watch_g = '{7'h40, 7'h30, 7'h7F, 7'h7F};
`else
        watch_g = '{7'h40, 7'h30, 7'h40, 7'h40};
`endif
        watch = 1'b1;
        run(20);
        watch = 1'b0;

        load_val(16'h1234);
        for (k = 0; k < 100; k++) begin
            if (m_run && m_full && (m_pos % P) >= RD) break;
            tick();
        end
        chk("find_guard", 32'(k < 100), 32'd1);
        rst = 1'b1;
        tick();
        chk_reset_outs("midrst");
        rst = 1'b0;
        run(2);
        watch_g = '{7'h40, 7'h40, 7'h40, 7'h40};
        watch = 1'b1;
        run(20);
        watch = 1'b0;
        run(5);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
